stream_demux_buf: RTL and testbench
===================================

Name: stream_demux_buf

Overview:
- Parametrised successor to the combinational 1:4 demux.
- Routes a valid/ready input stream to one of NUM_CH output channels, chosen by a per-beat select.
- Each channel has a DEPTH-entry FIFO with independent backpressure, so one stalled channel never blocks beats bound for other channels.
- Sits between a single producer and NUM_CH independent consumers.

Parameters:
- DATA_W, 3, width of one data beat
- NUM_CH, 4, number of output channels (2..16)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_CH
- DEPTH, 2, entries per channel FIFO; power of two, >= 2
- CNT_W, 8, width of the saturating drop counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  DATA_W  input beat
- in_sel  in  SEL_W  destination channel of the current beat
- in_valid  in  1  producer has a beat
- in_ready  out  1  block accepts the beat this cycle
- out_data  out  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- out_valid  out  NUM_CH  channel k FIFO is non-empty
- out_ready  in  NUM_CH  consumer k takes the head beat
- drop_cnt  out  CNT_W  count of beats accepted with an out-of-range select

Behaviour:
- Reset (async assert, sync release), effective immediately:
  - all FIFOs empty; pointers and storage cleared to 0
  - out_valid = 0, out_data = 0, drop_cnt = 0
  - in_ready evaluates from the empty state
- Input transfer occurs when in_valid & in_ready at a rising edge.
- in_ready is combinational from in_sel and the full flags only; it never depends on in_valid.
  - in_sel < NUM_CH: in_ready = !full[in_sel]
  - in_sel >= NUM_CH: in_ready = 1
- Out-of-range beats are consumed and discarded. drop_cnt increments by 1 per such transfer and saturates at 2**CNT_W-1.
- Latency: a beat accepted at edge t is visible on out_valid/out_data of its channel from t+1. There is no combinational bypass from input to output.
- Output transfer on channel k occurs when out_valid[k] & out_ready[k] at an edge; the head then advances.
- out_data slice k always shows the FIFO head entry. When the FIFO is empty it shows the last popped value, or 0 after reset.
- Ordering: FIFO order is preserved within a channel. No ordering is guaranteed across channels.
- Channel FIFO details:
  - read/write pointers of width log2(DEPTH), wrapping modulo DEPTH
  - occupancy count of width log2(DEPTH)+1
  - full when count == DEPTH; empty when count == 0
- Simultaneous push and pop on the same channel: the count is unchanged, both pointers advance, and out_valid stays 1.
- Full channel: a push is refused (in_ready = 0) even if a pop happens in the same cycle. Pop and push are not merged on a full FIFO.
- Pop while empty: impossible, since out_valid = 0; out_ready is ignored.
- Only one channel is pushed per cycle; any subset of channels may pop in the same cycle.
- There is no state machine beyond the per-channel counters; all channels are identical and independent.

Decomposition:
- Package demux_pkg holds:
  - default constants (DATA_W, NUM_CH, DEPTH)
  - a function computing the clog2-based pointer and count widths
- Sub-module demux_chan_fifo (DATA_W, DEPTH) implements one channel:
  - push/data_in/full on the write side; pop/data_out/valid on the read side
- The top level generates NUM_CH instances and adds select decode, the in_ready mux and the drop counter.

Test Plan:
- Routing with defaults, all out_ready = 0: push 3'b100 sel 0, 3'b110 sel 2, 3'b010 sel 1, 3'b101 sel 3 on consecutive edges.
  - Each out_valid[k] rises exactly one cycle after its push, with the matching out_data slice.
  - Untouched channels keep out_valid = 0.
- Backpressure on channel 1 (out_ready[1] = 0): push 3'b010 then 3'b011 to sel 1, then offer 3'b111 sel 1.
  - in_ready = 0 for the third beat, while sel 0 at the same time shows in_ready = 1.
  - Then raising out_ready[1] pops 010, then 011, then out_valid[1] = 0.
- Simultaneous push/pop on channel 2 holding one entry (3'b001): push 3'b110 with out_ready[2] = 1.
  - Head becomes 110 next cycle; out_valid[2] stays 1; occupancy remains 1.
- Wrap-around: stream 10 beats 0..7,0,1 to channel 0 with out_ready[0] toggling 1,0.
  - Output sequence is identical to the input, with no loss or duplication across pointer wrap.
- Drop path (NUM_CH = 3 instance): 260 beats with sel = 3.
  - in_ready = 1 throughout; no out_valid asserts.
  - drop_cnt reaches 255 and holds.
- Reset mid-operation: fill channels 0 and 3, then assert rst between clock edges.
  - out_valid = 0, out_data = 0 and drop_cnt = 0 immediately, without waiting for an edge.
  - After release, a push 3'b101 sel 3 appears one cycle later.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared defaults and width helpers for the stream demux and its channel FIFOs.
package demux_pkg;

  localparam int unsigned DEF_DATA_W = 3;
  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_DEPTH  = 2;

  // Pointer width; kept at least 1 bit so a degenerate depth still elaborates.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// One output channel: DEPTH-entry FIFO whose head (or last popped beat) is always on data_out_o.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_in_i,
  output logic              full_o,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              valid_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = count_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              push_en, pop_en;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & valid_o;

  // An empty FIFO keeps presenting the beat it last handed out.
  assign data_out_o = valid_o ? mem_q[rd_ptr_q] : last_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      if (push_en) mem_q[wr_ptr_q] <= data_in_i;
    end
  end

endmodule

// File: rtl/stream_demux_buf.sv
// 1:NUM_CH valid/ready stream demux with a buffered FIFO per channel and a drop counter for bad selects.
module stream_demux_buf
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [CNT_W-1:0]         drop_cnt
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic              sel_in_range;
  logic              sel_full;
  logic              xfer;
  logic [CNT_W-1:0]  drop_q, drop_d;

  // Ready looks only at the selected channel's full flag, never at in_valid.
  always_comb begin
    sel_in_range = (32'(in_sel) < NUM_CH);
    sel_full     = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (in_sel == SEL_W'(k)) sel_full = full[k];
    end
    in_ready = sel_in_range ? ~sel_full : 1'b1;
    xfer     = in_valid & in_ready;
    push     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      push[k] = xfer & (in_sel == SEL_W'(k));
    end
    drop_d = drop_q;
    if (xfer && !sel_in_range && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    demux_chan_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push[g]),
      .data_in_i (in_data),
      .full_o    (full[g]),
      .pop_i     (out_ready[g]),
      .data_out_o(out_data[g*DATA_W +: DATA_W]),
      .valid_o   (out_valid[g])
    );
  end

endmodule

// File: tb/tb_stream_demux_buf.sv
// Directed bench for stream_demux_buf with a per-channel queue scoreboard.
module tb_stream_demux_buf;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [11:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] drop_cnt;

  logic [2:0] in_data3;
  logic [1:0] in_sel3;
  logic       in_valid3;
  logic       in_ready3;
  logic [8:0] out_data3;
  logic [2:0] out_valid3;
  logic [2:0] out_ready3;
  logic [7:0] drop_cnt3;

  int tests = 0;
  int fails = 0;

  logic [2:0] q [4][$];
  logic [2:0] last [4];

  always #5 clk = ~clk;

  stream_demux_buf dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  stream_demux_buf #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .drop_cnt(drop_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks all outputs against the model, then clocks one edge and updates the model.
  task automatic cycle(output bit acc);
    bit rdy;
    logic [2:0] e;
    #1;
    rdy = (q[in_sel].size() < DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid%0d", k), {31'd0, out_valid[k]}, {31'd0, q[k].size() != 0});
      e = (q[k].size() != 0) ? q[k][0] : last[k];
      chk($sformatf("out_data%0d", k), {29'd0, out_data[k*3 +: 3]}, {29'd0, e});
    end
    chk("drop_cnt", {24'd0, drop_cnt}, 32'd0);
    acc = in_valid && rdy;
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (out_ready[k] && q[k].size() != 0) last[k] = q[k].pop_front();
    if (acc) q[in_sel].push_back(in_data);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [2:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic probe_ready(input logic [1:0] s, input logic exp, input string tag);
    in_sel = s;
    #1;
    chk(tag, {31'd0, in_ready}, {31'd0, exp});
  endtask

  initial begin
    bit acc;
    int i;
    int guard;
    rst = 1'b1;
    drive(1'b0, 2'd0, 3'd0);
    out_ready  = '0;
    in_data3   = '0;
    in_sel3    = '0;
    in_valid3  = 1'b0;
    out_ready3 = '0;
    for (int k = 0; k < 4; k++) last[k] = '0;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data", {20'd0, out_data}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // Routing: one beat per channel, no consumers ready.
    drive(1'b1, 2'd0, 3'b100); cycle(acc);
    drive(1'b1, 2'd2, 3'b110); cycle(acc);
    drive(1'b1, 2'd1, 3'b010); cycle(acc);
    drive(1'b1, 2'd3, 3'b101); cycle(acc);
    drive(1'b0, 2'd0, 3'b000); cycle(acc);
    out_ready = 4'b1111; cycle(acc);
    out_ready = 4'b0000; cycle(acc);

    // Backpressure on channel 1.
    drive(1'b1, 2'd1, 3'b010); cycle(acc);
    drive(1'b1, 2'd1, 3'b011); cycle(acc);
    drive(1'b1, 2'd1, 3'b111); cycle(acc);
    chk("bp_refused", {31'd0, acc}, 32'd0);
    in_valid = 1'b0;
    probe_ready(2'd0, 1'b1, "bp_sel0_ready");
    probe_ready(2'd1, 1'b0, "bp_sel1_ready");
    out_ready[1] = 1'b1;
    cycle(acc); cycle(acc); cycle(acc);
    out_ready[1] = 1'b0;

    // Simultaneous push and pop on channel 2 holding one entry.
    drive(1'b1, 2'd2, 3'b001); cycle(acc);
    out_ready[2] = 1'b1;
    drive(1'b1, 2'd2, 3'b110); cycle(acc);
    chk("pp_accept", {31'd0, acc}, 32'd1);
    drive(1'b0, 2'd0, 3'b000); cycle(acc);
    cycle(acc);
    out_ready[2] = 1'b0;

    // Wrap-around on channel 0 with a toggling consumer.
    i = 0;
    guard = 0;
    while (i < 10 && guard < 100) begin
      drive(1'b1, 2'd0, 3'(i));
      out_ready[0] = ~guard[0];
      cycle(acc);
      if (acc) i++;
      guard++;
    end
    chk("wrap_done", {31'd0, i == 10}, 32'd1);
    in_valid = 1'b0;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) cycle(acc);
    out_ready[0] = 1'b0;

    // Drop path on the three-channel instance.
    in_valid3 = 1'b1;
    in_sel3   = 2'd3;
    for (int n = 1; n <= 260; n++) begin
      in_data3 = 3'(n);
      #1;
      chk("drop_ready", {31'd0, in_ready3}, 32'd1);
      @(posedge clk); #1;
      chk("drop_valid", {29'd0, out_valid3}, 32'd0);
      chk("drop_cnt3", {24'd0, drop_cnt3}, (n > 255) ? 32'd255 : 32'(n));
    end
    in_valid3 = 1'b0;

    // Reset mid-operation with channels 0 and 3 holding data.
    drive(1'b1, 2'd0, 3'b011); cycle(acc);
    drive(1'b1, 2'd3, 3'b110); cycle(acc);
    drive(1'b0, 2'd0, 3'b000);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data", {20'd0, out_data}, 32'd0);
    chk("mid_rst_drop_cnt3", {24'd0, drop_cnt3}, 32'd0);
    chk("mid_rst_out_data3", {23'd0, out_data3}, 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      last[k] = '0;
    end
    @(posedge clk); #1;
    drive(1'b1, 2'd3, 3'b101); cycle(acc);
    drive(1'b0, 2'd0, 3'b000);
    chk("post_rst_valid3", {31'd0, out_valid[3]}, 32'd1);
    chk("post_rst_data3", {29'd0, out_data[9 +: 3]}, 32'b101);
    cycle(acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
